stopwatch_counter: RTL and testbench
====================================

# stopwatch_counter

Timekeeping core that produces the 12-bit elapsed-seconds value consumed by the 7-segment display driver. The count runs 00:00 to 59:59 as total seconds 0..3599 and is split by the display into MM:SS digits. It advances on a 1 Hz enable pulse and supports pause/resume and clear. In adjust mode it increments the minutes or seconds field at 2 Hz. It sits between the clock-enable divider / button debouncers and the display block, and drives the display's `number_to_disp`.

## Interface
Parameters:
- `MAX_FIELD`, 59, terminal value of both the minutes and seconds fields.

Ports:
- `clk`  input  1  system clock; all logic is on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `tick_1hz`  input  1  one-`clk`-wide count enable, 1 Hz.
- `tick_2hz`  input  1  one-`clk`-wide adjust enable, 2 Hz.
- `adj`  input  1  level; 1 = adjust mode.
- `sel`  input  1  level; field select in adjust mode: 1 = seconds, 0 = minutes. Matches the display blink convention.
- `pause_pulse`  input  1  one-cycle debounced pulse; toggles run/pause.
- `clear_pulse`  input  1  one-cycle debounced pulse; zeroes the count.
- `number_to_disp`  output  12  registered total seconds, min*60+sec, range 0..3599.
- `running`  output  1  registered; 1 in RUN state.

## Operation
- Internal state: `sec` (6 bits, 0..59), `min` (6 bits, 0..59), and a 1-bit state (PAUSED, RUN).
- `number_to_disp` is registered from the *next* values of `min` and `sec`. It never exceeds 3599.
- Reset (asynchronous, `rst_n`=0): `sec`=0, `min`=0, state=PAUSED, `number_to_disp`=0, `running`=0.
- Priority per cycle, highest first: clear, adjust, run/pause.
- Clear (`clear_pulse`=1):
  - `sec`=0, `min`=0, state=PAUSED.
  - Overrides all other inputs in the same cycle, including `adj`.
- Adjust (`adj`=1, no clear):
  - Normal counting is frozen, and `tick_1hz` is ignored.
  - `pause_pulse` is ignored. The state is retained and restored when `adj` falls.
  - On `tick_2hz`, with `sel`=1: `sec` = (`sec`==59) ? 0 : `sec`+1. `min` is unchanged, so there is no carry.
  - On `tick_2hz`, with `sel`=0: `min` = (`min`==59) ? 0 : `min`+1. `sec` is unchanged.
  - Adjust works in either run state.
- Normal mode (`adj`=0, no clear):
  - `pause_pulse` toggles PAUSED and RUN.
  - In RUN, on `tick_1hz`:
    - `sec` increments.
    - When `sec`==59: `sec`=0 and `min` increments.
    - When `min`==59 and `sec`==59: both fields wrap to 0, so the count goes 3599→0.
  - If `tick_1hz` and `pause_pulse` arrive in the same cycle, the tick is evaluated against the pre-toggle state:
    - RUN + tick + pause: the count increments, then the state becomes PAUSED.
    - PAUSED + tick + pause: no increment, then the state becomes RUN.
- `tick_2hz` has no effect outside adjust. `tick_1hz` has no effect inside adjust.
- `sel` changes take effect on the next `tick_2hz`. There is no side effect on a change.

## Timing
- All outputs are registered. An event sampled at edge N is visible on `number_to_disp` and `running` after edge N.
- Latency: one `clk` from a qualifying tick or pulse to the output.
- Pulses longer than one cycle are the debouncer's responsibility; each high cycle of `pause_pulse` toggles the state once.
- `rst_n` assertion clears the outputs immediately without a clock edge.
- Deassertion is synchronized externally. The first active edge after deassertion uses normal rules.
- Reset mid-adjust or mid-run returns to 0/PAUSED. No stale field survives.

## Test plan
- Reset and start:
  - Stimulus: assert `rst_n`=0 → required: `number_to_disp`=0, `running`=0.
  - Stimulus: release, `pause_pulse`, then 61 `tick_1hz` → required: `running`=1, `number_to_disp`=61.
- Wrap:
  - Stimulus: preload to 3598 via adjust, RUN, two ticks → required: 3599, then 0.
  - Stimulus: one tick at 59 → required: 60.
- Pause:
  - Stimulus: at 100, `pause_pulse` with a coincident `tick_1hz` → required: 101 and PAUSED.
  - Stimulus: five further ticks → required: still 101.
- Adjust seconds:
  - Stimulus: count 779 (12:59), `adj`=1, `sel`=1, one `tick_2hz` → required: 720 (12:00).
  - Stimulus: `tick_1hz` during adjust → required: ignored.
  - Stimulus: `adj`=0 → required: RUN resumes.
- Adjust minutes:
  - Stimulus: count 3570 (59:30), `sel`=0, one `tick_2hz` → required: 30 (00:30).
  - Stimulus: `pause_pulse` during adjust → required: `running` unchanged.
- Clear priority:
  - Stimulus: RUN at 500, `clear_pulse` coincident with `tick_1hz` and `adj`=1 → required: 0 and PAUSED next cycle.
  - Stimulus: async `rst_n` pulse mid-count → required: immediate 0.

Source files
------------

// File: rtl/stopwatch_counter.sv
// -----------------------------------------------------------------------------
// stopwatch_counter
//
// Purpose:
//   Holds the MM:SS elapsed time for the display. The time runs from 00:00 to
//   59:59 and is presented as total seconds (min*60+sec, 0..3599).
//   - The count advances on a 1 Hz enable while running.
//   - pause_pulse toggles between run and pause.
//   - clear_pulse zeroes the count and pauses.
//   - In adjust mode, the selected field steps at 2 Hz. There is no carry
//     between fields, and the run/pause state is held.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   tick_1hz       in   one-cycle count enable (1 Hz)
//   tick_2hz       in   one-cycle adjust enable (2 Hz)
//   adj            in   level, 1 = adjust mode
//   sel            in   level, adjust field: 1 = seconds, 0 = minutes
//   pause_pulse    in   one-cycle pulse, toggles run/pause
//   clear_pulse    in   one-cycle pulse, zeroes the count
//   number_to_disp out  registered total seconds, 0..3599
//   running        out  registered, 1 while in RUN
// -----------------------------------------------------------------------------
module stopwatch_counter #(
  parameter int MAX_FIELD = 59
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_1hz,
  input  logic        tick_2hz,
  input  logic        adj,
  input  logic        sel,
  input  logic        pause_pulse,
  input  logic        clear_pulse,
  output logic [11:0] number_to_disp,
  output logic        running
);

  localparam logic [5:0]  LP_MAX  = 6'(MAX_FIELD);
  localparam logic [11:0] LP_BASE = 12'(MAX_FIELD + 1);

  typedef enum logic {
    ST_PAUSED = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [5:0]  r_sec;
  logic [5:0]  r_min;
  logic [5:0]  w_sec_next;
  logic [5:0]  w_min_next;
  logic [5:0]  w_sec_inc;
  logic [5:0]  w_min_inc;
  logic [11:0] r_number;
  logic [11:0] w_number_next;

  // Wrapping increments of each field. These are shared by counting and
  // adjusting.
  assign w_sec_inc = (r_sec == LP_MAX) ? 6'd0 : r_sec + 6'd1;
  assign w_min_inc = (r_min == LP_MAX) ? 6'd0 : r_min + 6'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_PAUSED;
      r_sec    <= 6'd0;
      r_min    <= 6'd0;
      r_number <= 12'd0;
    end else begin
      r_state  <= w_state_next;
      r_sec    <= w_sec_next;
      r_min    <= w_min_next;
      r_number <= w_number_next;
    end
  end

  // Priority: clear > adjust > normal run/pause.
  always_comb begin
    w_state_next = r_state;
    w_sec_next   = r_sec;
    w_min_next   = r_min;
    if (clear_pulse) begin
      w_state_next = ST_PAUSED;
      w_sec_next   = 6'd0;
      w_min_next   = 6'd0;
    end else if (adj) begin
      // In adjust mode, the state is frozen and tick_1hz and pause_pulse are
      // ignored.
      if (tick_2hz) begin
        if (sel) begin
          w_sec_next = w_sec_inc;
        end else begin
          w_min_next = w_min_inc;
        end
      end
    end else begin
      if (pause_pulse) begin
        w_state_next = (r_state == ST_RUN) ? ST_PAUSED : ST_RUN;
      end
      // The tick is judged against the pre-toggle state.
      if ((r_state == ST_RUN) && tick_1hz) begin
        w_sec_next = w_sec_inc;
        if (r_sec == LP_MAX) begin
          w_min_next = w_min_inc;
        end
      end
    end
  end

  // The display value is built from the next field values, so it updates on
  // the same edge as the fields themselves.
  assign w_number_next = 12'(w_min_next) * LP_BASE + 12'(w_sec_next);

  assign number_to_disp = r_number;
  assign running        = (r_state == ST_RUN);

endmodule

// File: tb/tb_stopwatch_counter.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_counter
//
// Purpose:
//   Directed self-checking bench for stopwatch_counter. Expected values are
//   hand-computed from the MM:SS arithmetic. Inputs are driven on the falling
//   edge. Outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_stopwatch_counter;

  logic        clk;
  logic        rst_n;
  logic        tick_1hz;
  logic        tick_2hz;
  logic        adj;
  logic        sel;
  logic        pause_pulse;
  logic        clear_pulse;
  logic [11:0] number_to_disp;
  logic        running;

  int n_cmp;
  int n_err;

  stopwatch_counter #(.MAX_FIELD(59)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tick_1hz       (tick_1hz),
    .tick_2hz       (tick_2hz),
    .adj            (adj),
    .sel            (sel),
    .pause_pulse    (pause_pulse),
    .clear_pulse    (clear_pulse),
    .number_to_disp (number_to_disp),
    .running        (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Apply one cycle of inputs. Pulses drop again after the edge.
  task automatic step(input logic t1, input logic t2, input logic a,
                      input logic s, input logic p, input logic c);
    @(negedge clk);
    tick_1hz    = t1;
    tick_2hz    = t2;
    adj         = a;
    sel         = s;
    pause_pulse = p;
    clear_pulse = c;
    @(posedge clk);
    #1;
    tick_1hz    = 1'b0;
    tick_2hz    = 1'b0;
    pause_pulse = 1'b0;
    clear_pulse = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic adj_steps(input logic s, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, s, 1'b0, 1'b0);
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst_n       = 1'b0;
    tick_1hz    = 1'b0;
    tick_2hz    = 1'b0;
    adj         = 1'b0;
    sel         = 1'b0;
    pause_pulse = 1'b0;
    clear_pulse = 1'b0;

    // Reset state
    #12;
    check("reset_num", number_to_disp, 0);
    check("reset_run", running, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Start and count 61 s (01:01)
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("start_run", running, 1);
    ticks(61);
    check("count_61", number_to_disp, 61);
    check("count_61_run", running, 1);

    // Clear, then preload 59:58 through adjust while paused
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("clear_num", number_to_disp, 0);
    check("clear_run", running, 0);
    adj_steps(1'b0, 59);
    adj_steps(1'b1, 58);
    check("preload_3598", number_to_disp, 3598);
    check("preload_paused", running, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("resume_run", running, 1);
    ticks(1);
    check("wrap_3599", number_to_disp, 3599);
    ticks(1);
    check("wrap_0", number_to_disp, 0);
    ticks(59);
    check("at_59", number_to_disp, 59);
    ticks(1);
    check("carry_60", number_to_disp, 60);

    // Pause with a coincident tick: the increment still happens
    ticks(40);
    check("at_100", number_to_disp, 100);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("pause_tick_num", number_to_disp, 101);
    check("pause_tick_run", running, 0);
    ticks(5);
    check("paused_hold", number_to_disp, 101);
    // Resume with a coincident tick: no increment happens
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("resume_tick_num", number_to_disp, 101);
    check("resume_tick_run", running, 1);

    // Adjust seconds at 12:59
    ticks(678);
    check("at_779", number_to_disp, 779);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("adj_sec_wrap", number_to_disp, 720);
    check("adj_keeps_run", running, 1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("adj_ignores_1hz", number_to_disp, 720);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks(1);
    check("run_after_adj", number_to_disp, 721);
    check("run_after_adj_r", running, 1);

    // Adjust minutes at 59:30. Starting from 12:01: +47 min, +29 s
    adj_steps(1'b0, 47);
    adj_steps(1'b1, 29);
    check("at_3570", number_to_disp, 3570);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("adj_min_wrap", number_to_disp, 30);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("adj_ignores_pause", running, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("2hz_outside_adj", number_to_disp, 30);

    // Clear overrides tick and adjust
    ticks(470);
    check("at_500", number_to_disp, 500);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("clear_prio_num", number_to_disp, 0);
    check("clear_prio_run", running, 0);

    // Asynchronous reset mid-count
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    ticks(3);
    check("pre_reset_3", number_to_disp, 3);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_num", number_to_disp, 0);
    check("async_rst_run", running, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ticks(2);
    check("post_reset_paused", number_to_disp, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
